// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response bundle for the fetch stage
//
// Purpose: groups the fetch stage's instruction-memory handshake into one bundle.
//   master : fetch stage side (drives the request, receives ready and read data)
//   slave  : instruction memory side
// Signals:
//   imem_req    fetch request valid
//   imem_addr   fetch address
//   imem_ready  memory accepts the request this cycle
//   imem_rvalid read data valid, one per accepted request
//   imem_rdata  fetched instruction word
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage feeding the IF/ID segment register
//
// Purpose: owns the fetch PC, keeps at most one instruction-memory request in
// flight, parks each returned word in a one-entry holding buffer and offers it
// (or a bubble) to IF/ID every cycle. A redirect squashes wrong-path fetches.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             IF/ID holds and does not consume the offered item
//   redirect          branch/jump taken, redirect_pc is the new fetch target
//   imem              instruction-memory request/response bundle (master side)
//   pc_out            PC of the offered instruction
//   instruction_out   offered instruction word
//   bubble_out        1 = nothing valid offered, IF/ID loads zeros
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              pc_out,
    output logic [31:0]              instruction_out,
    output logic                     bubble_out
);

    // S_DISCARD waits out a response that belongs to a squashed fetch.
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] ppc_q, ppc_d;
    logic        hv_q, hv_d;
    logic [31:0] hpc_q, hpc_d;
    logic [31:0] hinstr_q, hinstr_d;

    logic        req;
    logic        handshake;
    logic        bubble;

    // A request is only raised when the buffer is empty or is being consumed
    // this cycle, so the buffer is always free when the response returns.
    assign req       = ~rst & (state_q == S_REQ) & ~redirect & (~hv_q | ~stall);
    assign handshake = req & imem.imem_ready;
    assign bubble    = rst | ~hv_q | redirect;

    assign imem.imem_req   = req;
    assign imem.imem_addr  = fpc_q;
    assign bubble_out      = bubble;
    assign pc_out          = bubble ? 32'h0 : hpc_q;
    assign instruction_out = bubble ? 32'h0 : hinstr_q;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        ppc_d    = ppc_q;
        hv_d     = hv_q;
        hpc_d    = hpc_q;
        hinstr_d = hinstr_q;

        if (redirect) begin
            // Redirect wins over stall and over any response in this cycle.
            fpc_d = redirect_pc;
            hv_d  = 1'b0;
            ppc_d = 32'h0;
            unique case (state_q)
                S_REQ:     state_d = S_REQ;
                S_WAIT:    state_d = imem.imem_rvalid ? S_REQ : S_DISCARD;
                S_DISCARD: state_d = imem.imem_rvalid ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end else begin
            if (!stall) begin
                hv_d = 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (handshake) begin
                        fpc_d   = fpc_q + PC_STEP;
                        ppc_d   = fpc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        hv_d     = 1'b1;
                        hpc_d    = ppc_q;
                        hinstr_d = imem.imem_rdata;
                        state_d  = S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem.imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            fpc_q    <= RESET_PC;
            ppc_q    <= 32'h0;
            hv_q     <= 1'b0;
            hpc_q    <= 32'h0;
            hinstr_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            ppc_q    <= ppc_d;
            hv_q     <= hv_d;
            hpc_q    <= hpc_d;
            hinstr_q <= hinstr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STEP   = 32'd4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, instruction_out;
    logic        bubble_out;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(STEP)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (bus),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .bubble_out      (bubble_out)
    );

    // Second instance exercising the wrap-around reset PC.
    logic        rst2 = 1'b1;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] pc_out2, instruction_out2;
    logic        bubble_out2;

    if_fetch_stage_if bus2 ();

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_dut2 (
        .clk             (clk),
        .rst             (rst2),
        .stall           (stall2),
        .redirect        (redirect2),
        .redirect_pc     (redirect_pc2),
        .imem            (bus2),
        .pc_out          (pc_out2),
        .instruction_out (instruction_out2),
        .bubble_out      (bubble_out2)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: fetch PC, queue of in-flight requests and queue of
    // buffered instructions offered to IF/ID.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
    typedef struct { logic [31:0] pc; bit squashed; } pend_t;
    item_t       m_buf[$];
    pend_t       m_out[$];
    logic [31:0] m_fpc = RST_PC;

    // Memory model: latency counted in cycles after acceptance.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat = 1;
    bit          dead_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input logic r, input logic st, input logic rd,
                         input logic [31:0] rp, input logic rdy);
        logic        e_req, e_bub, acc;
        logic [31:0] e_pc, e_ins;
        pend_t       p;
        item_t       it;
        @(posedge clk);
        #1;
        rst = r; stall = st; redirect = rd; redirect_pc = rp;
        bus.imem_ready  = rdy;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mem_busy && mem_cnt == 1 && !r) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = dead_mode ? 32'hDEAD_BEEF : 32'h1111_0000 + mem_addr;
        end
        @(negedge clk);
        if (r) begin
            e_req = 1'b0; e_bub = 1'b1; e_pc = 32'h0; e_ins = 32'h0;
        end else begin
            e_req = (m_out.size() == 0) && !rd && (m_buf.size() == 0 || !st);
            e_bub = (m_buf.size() == 0) || rd;
            e_pc  = e_bub ? 32'h0 : m_buf[0].pc;
            e_ins = e_bub ? 32'h0 : m_buf[0].instr;
        end
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, e_req});
        if (!r) chk("imem_addr", bus.imem_addr, m_fpc);
        chk("bubble_out", {31'h0, bubble_out}, {31'h0, e_bub});
        chk("pc_out", pc_out, e_pc);
        chk("instruction_out", instruction_out, e_ins);

        acc = e_req && rdy;
        if (r) begin
            m_fpc = RST_PC;
            m_buf.delete();
            m_out.delete();
            mem_busy = 0;
        end else begin
            if (!st && !rd) m_buf.delete();
            if (rd) begin
                m_buf.delete();
                m_fpc = rp;
                foreach (m_out[i]) m_out[i].squashed = 1;
            end
            if (bus.imem_rvalid && m_out.size() > 0) begin
                p = m_out.pop_front();
                if (!p.squashed) begin
                    it.pc = p.pc;
                    it.instr = bus.imem_rdata;
                    m_buf.push_back(it);
                end
            end
            if (mem_busy) begin
                if (mem_cnt == 1) mem_busy = 0;
                else mem_cnt--;
            end
            if (acc) begin
                p.pc = m_fpc;
                p.squashed = 0;
                m_out.push_back(p);
                mem_busy = 1;
                mem_cnt  = lat;
                mem_addr = m_fpc;
                m_fpc    = m_fpc + STEP;
            end
        end
    endtask

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;

        // Straight-line fetch with 1-cycle memory.
        cycle(1, 0, 0, 0, 1);
        chk("rst_bubble", {31'h0, bubble_out}, 32'h1);
        cycle(0, 0, 0, 0, 1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_req", {31'h0, bus.imem_req}, 32'h1);
        cycle(0, 0, 0, 0, 1);
        chk("gap_bubble", {31'h0, bubble_out}, 32'h1);
        cycle(0, 0, 0, 0, 1);
        chk("item0_pc", pc_out, 32'h0);
        chk("item0_instr", instruction_out, 32'h1111_0000);
        chk("second_addr", bus.imem_addr, 32'h4);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("item1_instr", instruction_out, 32'h1111_0004);
        cycle(0, 0, 0, 0, 1);

        // Stall with a full buffer.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1);
        chk("stall_pc_held", pc_out, 32'h8);
        chk("stall_no_req", {31'h0, bus.imem_req}, 32'h0);
        lat = 3;
        cycle(0, 0, 0, 0, 1);
        chk("after_stall_addr", bus.imem_addr, 32'hC);

        // Redirect while waiting; the late response must be dropped.
        dead_mode = 1;
        cycle(0, 0, 1, 32'h40, 1);
        chk("redir_bubble", {31'h0, bubble_out}, 32'h1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("dead_dropped", instruction_out, 32'h0);
        dead_mode = 0;
        lat = 1;

        // Memory not ready for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk("notready_addr", bus.imem_addr, 32'h40);
            chk("notready_req", {31'h0, bus.imem_req}, 32'h1);
        end
        cycle(0, 0, 0, 0, 1);
        // Redirect coinciding with rvalid.
        cycle(0, 0, 1, 32'h80, 1);
        chk("redir_rvalid_bubble", {31'h0, bubble_out}, 32'h1);
        cycle(0, 0, 0, 0, 1);
        chk("redir_rvalid_addr", bus.imem_addr, 32'h80);
        cycle(0, 0, 0, 0, 1);
        // Redirect with stall and a full buffer.
        cycle(0, 1, 1, 32'h100, 1);
        chk("redir_stall_bubble", {31'h0, bubble_out}, 32'h1);
        chk("redir_stall_req", {31'h0, bus.imem_req}, 32'h0);
        cycle(0, 0, 0, 0, 1);
        chk("redir_stall_addr", bus.imem_addr, 32'h100);
        chk("redir_stall_bubble2", {31'h0, bubble_out}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 3);
            cycle(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 10) == 0,
                  $urandom & 32'hFFFF_FFFC, ($urandom % 3) != 0);
        end

        // Wrap-around reset PC instance.
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        chk("w_rst_req", {31'h0, bus2.imem_req}, 32'h0);
        chk("w_rst_bubble", {31'h0, bubble_out2}, 32'h1);
        @(posedge clk); #1;
        rst2 = 1'b0; bus2.imem_ready = 1'b1;
        @(negedge clk);
        chk("w_req", {31'h0, bus2.imem_req}, 32'h1);
        chk("w_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w_wait_noreq", {31'h0, bus2.imem_req}, 32'h0);
        @(posedge clk); #1;
        bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("w_bubble_pre", {31'h0, bubble_out2}, 32'h1);
        @(posedge clk); #1;
        bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        @(negedge clk);
        chk("w_pc", pc_out2, 32'hFFFF_FFFC);
        chk("w_instr", instruction_out2, 32'hCAFE_0001);
        chk("w_wrap_addr", bus2.imem_addr, 32'h0);
        chk("w_wrap_req", {31'h0, bus2.imem_req}, 32'h1);
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        chk("w_rstwait_req", {31'h0, bus2.imem_req}, 32'h0);
        chk("w_rstwait_bubble", {31'h0, bubble_out2}, 32'h1);
        @(posedge clk); #1;
        rst2 = 1'b0; bus2.imem_ready = 1'b0;
        @(negedge clk);
        chk("w_after_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("w_after_rst_bubble", {31'h0, bubble_out2}, 32'h1);
        chk("w_after_rst_req", {31'h0, bus2.imem_req}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
